// File: rtl/dac_switch_sequencer.sv
// dac_switch_sequencer: stream/sweep code sequencer driving binary and unary DAC switch selects.
// Optional DAC_DEM_ROTATE_EN rotates the unary selects (data-weighted averaging).
module dac_switch_sequencer #(
   parameter int NBITS = 10,
   parameter int NBIN  = 6,
   parameter int DIV_W = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          mode_sweep,
   input  logic [DIV_W-1:0]              rate_div,
   input  logic [NBITS-1:0]              sweep_step,
   input  logic [NBITS-1:0]              code_in,
   input  logic                          code_valid,
   output logic                          code_ready,
   output logic [NBIN-1:0]               sw_bin,
   output logic [(1<<(NBITS-NBIN))-2:0]  sw_therm,
   output logic [NBITS-1:0]              code_out,
   output logic                          upd,
   output logic                          underrun,
   output logic                          sweep_done
);
   localparam int NTHERM = NBITS - NBIN;
   localparam int NU = (1 << NTHERM) - 1;
   typedef enum logic [1:0] {IDLE, STREAM, SWEEP, DONE} state_t;
   state_t state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
   logic [NBITS-1:0] hold_q, hold_d, ramp_q, ramp_d, code_q, app_code, step_eff, ramp_sat;
   logic [NBITS:0] ramp_sum;
   logic [NBIN-1:0] bin_q;
   logic [NU-1:0] therm_q, therm_fix, therm_app;
   logic [NTHERM-1:0] m;
   logic full_q, full_d, upd_q, unr_q, unr_d, tick, xfer, apply;
   assign tick = (state_q != IDLE) && (cnt_q == div_q);
   assign code_ready = en && (state_q == STREAM) && (!full_q || tick);
   assign xfer = code_valid && code_ready;
   assign sweep_done = (state_q == DONE);
   assign step_eff = (sweep_step == '0) ? NBITS'(1) : sweep_step;
   // Sum one bit wider than the code so saturation sees the carry instead of a wrap.
   assign ramp_sum = {1'b0, ramp_q} + {1'b0, step_eff};
   assign ramp_sat = ramp_sum[NBITS] ? '1 : ramp_sum[NBITS-1:0];
   assign m = app_code[NBITS-1:NBIN];
   always_comb begin
      for (int i = 0; i < NU; i++) therm_fix[i] = i < int'(m);
   end
`ifdef DAC_DEM_ROTATE_EN
   localparam logic [NTHERM:0] NU_W = (NTHERM+1)'(NU);
   logic [NTHERM-1:0] p_q;
   logic [NTHERM:0] p_sum, p_nx;
   logic [2*NU-1:0] rot;
   // Upper half of the doubled mask is the mask rotated left by p modulo NU.
   assign rot = {therm_fix, therm_fix} << p_q;
   assign therm_app = rot[2*NU-1:NU];
   assign p_sum = {1'b0, p_q} + {1'b0, m};
   assign p_nx = (p_sum >= NU_W) ? p_sum - NU_W : p_sum;
   always_ff @(posedge clk) begin
      if (rst) p_q <= '0;
      else if (apply) p_q <= p_nx[NTHERM-1:0];
   end
`else
   assign therm_app = therm_fix;
`endif
   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      full_d = full_q;
      ramp_d = ramp_q;
      app_code = hold_q;
      apply = 1'b0;
      unr_d = 1'b0;
      div_d = (state_q == IDLE || tick) ? rate_div : div_q;
      cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            state_d = en ? (mode_sweep ? SWEEP : STREAM) : IDLE;
            ramp_d = '0;
         end
         STREAM: begin
            if (mode_sweep) begin
               state_d = SWEEP;
               full_d = 1'b0;
               ramp_d = '0;
            end else begin
               apply = tick && full_q;
               unr_d = tick && !full_q;
               full_d = tick ? xfer : (full_q || xfer);
               hold_d = xfer ? code_in : hold_q;
            end
         end
         SWEEP: begin
            app_code = ramp_q;
            apply = tick;
            ramp_d = tick ? ramp_sat : ramp_q;
            state_d = (tick && ramp_q == '1) ? DONE : SWEEP;
         end
         default: state_d = mode_sweep ? DONE : IDLE;
      endcase
      if (!en) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         div_q <= '0;
         hold_q <= '0;
         full_q <= 1'b0;
         ramp_q <= '0;
         code_q <= '0;
         bin_q <= '0;
         therm_q <= '0;
         upd_q <= 1'b0;
         unr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
         hold_q <= hold_d;
         full_q <= full_d;
         ramp_q <= ramp_d;
         code_q <= apply ? app_code : code_q;
         bin_q <= apply ? app_code[NBIN-1:0] : bin_q;
         therm_q <= apply ? therm_app : therm_q;
         upd_q <= apply;
         unr_q <= unr_d;
      end
   end
   assign code_out = code_q;
   assign sw_bin = bin_q;
   assign sw_therm = therm_q;
   assign upd = upd_q;
   assign underrun = unr_q;
endmodule

// File: tb/tb_dac_switch_sequencer.sv
// tb_dac_switch_sequencer: directed vector table plus multi-cycle stream/sweep/reset sequences.
module tb_dac_switch_sequencer;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, mode_sweep = 1'b0, code_valid = 1'b0;
   logic [7:0] rate_div = 8'd3;
   logic [9:0] sweep_step = 10'd0, code_in = 10'd0;
   logic code_ready, upd, underrun, sweep_done;
   logic [5:0] sw_bin;
   logic [14:0] sw_therm;
   logic [9:0] code_out;
   int checks = 0, errors = 0;
   typedef struct {logic [9:0] code; logic [5:0] bin; logic [14:0] therm;} vec_t;
   vec_t tv[$];
   int got[$];
   dac_switch_sequencer dut (
      .clk(clk), .rst(rst), .en(en), .mode_sweep(mode_sweep), .rate_div(rate_div),
      .sweep_step(sweep_step), .code_in(code_in), .code_valid(code_valid),
      .code_ready(code_ready), .sw_bin(sw_bin), .sw_therm(sw_therm), .code_out(code_out),
      .upd(upd), .underrun(underrun), .sweep_done(sweep_done)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic wait_upd(input string name);
      int n = 0;
      while (!upd && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!upd) begin
         errors++;
         checks++;
         $display("FAIL %s: upd timeout got 0 expected 1", name);
      end
   endtask
   task automatic send(input logic [9:0] c);
      int n = 0;
      @(negedge clk);
      code_in = c;
      code_valid = 1'b1;
      while (!code_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!code_ready) begin
         errors++;
         checks++;
         $display("FAIL send_ready: got 0 expected 1");
      end
      @(negedge clk);
      code_valid = 1'b0;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en = 1'b0;
      mode_sweep = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic run_sweep(input int budget);
      got.delete();
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (upd) got.push_back(int'(code_out));
         if (sweep_done) break;
      end
   endtask
   initial begin
`ifdef DAC_DEM_ROTATE_EN
      tv.push_back('{10'h145, 6'h05, 15'h001F});
      tv.push_back('{10'h140, 6'h00, 15'h03E0});
      tv.push_back('{10'h1C0, 6'h00, 15'h7C03});
      tv.push_back('{10'h000, 6'h00, 15'h0000});
      tv.push_back('{10'h3FF, 6'h3F, 15'h7FFF});
`else
      tv.push_back('{10'h2A5, 6'h25, 15'h03FF});
      tv.push_back('{10'h000, 6'h00, 15'h0000});
      tv.push_back('{10'h3FF, 6'h3F, 15'h7FFF});
      tv.push_back('{10'h040, 6'h00, 15'h0001});
      tv.push_back('{10'h03F, 6'h3F, 15'h0000});
      tv.push_back('{10'h1C7, 6'h07, 15'h007F});
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_code_out", 32'(code_out), 0);
      check("rst_sw_bin", 32'(sw_bin), 0);
      check("rst_sw_therm", 32'(sw_therm), 0);
      check("rst_upd", 32'(upd), 0);
      check("rst_ready", 32'(code_ready), 0);
      check("rst_done", 32'(sweep_done), 0);
      en = 1'b1;
      foreach (tv[k]) begin
         send(tv[k].code);
         wait_upd("stream_upd");
         check("stream_code_out", 32'(code_out), 32'(tv[k].code));
         check("stream_sw_bin", 32'(sw_bin), 32'(tv[k].bin));
         check("stream_sw_therm", 32'(sw_therm), 32'(tv[k].therm));
      end
      begin
         int nu = 0, nd = 0;
         @(negedge clk);
         for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            nu += int'(underrun);
            nd += int'(upd);
         end
         check("underrun_pulses", 32'(nu), 4);
         check("underrun_no_upd", 32'(nd), 0);
         check("underrun_hold", 32'(code_out), 32'(tv[tv.size()-1].code));
      end
      do_reset();
      rate_div = 8'd0;
      sweep_step = 10'd100;
      mode_sweep = 1'b1;
      en = 1'b1;
      run_sweep(200);
      check("sweep100_len", 32'(got.size()), 12);
      for (int k = 0; k < got.size() && k < 12; k++)
         check("sweep100_code", 32'(got[k]), (k == 11) ? 1023 : 100 * k);
      check("sweep100_done", 32'(sweep_done), 1);
      check("sweep100_bin", 32'(sw_bin), 32'h3F);
`ifndef DAC_DEM_ROTATE_EN
      check("sweep100_therm", 32'(sw_therm), 32'h7FFF);
`endif
      check("sweep100_ready", 32'(code_ready), 0);
      @(negedge clk);
      check("done_hold", 32'(code_out), 1023);
      mode_sweep = 1'b0;
      @(negedge clk);
      check("done_exit", 32'(sweep_done), 0);
      do_reset();
      sweep_step = 10'd0;
      mode_sweep = 1'b1;
      en = 1'b1;
      run_sweep(3000);
      check("sweep1_len", 32'(got.size()), 1024);
      begin
         int bad = 0;
         foreach (got[k]) if (got[k] != k) bad++;
         check("sweep1_codes", 32'(bad), 0);
      end
      check("sweep1_done", 32'(sweep_done), 1);
      do_reset();
      rate_div = 8'd3;
      sweep_step = 10'd100;
      mode_sweep = 1'b1;
      en = 1'b1;
      begin
         int n = 0;
         while (code_out != 10'd500 && n < 400) begin
            @(negedge clk);
            n++;
         end
         check("midsweep_reach500", 32'(code_out), 500);
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst_code_out", 32'(code_out), 0);
      check("midrst_sw_bin", 32'(sw_bin), 0);
      check("midrst_sw_therm", 32'(sw_therm), 0);
      check("midrst_upd", 32'(upd), 0);
      rst = 1'b0;
      @(negedge clk);
      wait_upd("restart_upd0");
      check("restart_code0", 32'(code_out), 0);
      @(negedge clk);
      wait_upd("restart_upd1");
      check("restart_code1", 32'(code_out), 100);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
